// File: rtl/winograd_ewmm_accum_ctrl_if.sv
// Handshake bundle between the Winograd EWMM accumulation controller, its tile source,
// the shared 6x6 pointwise multiplier and the accumulated-tile consumer.
interface winograd_ewmm_accum_ctrl_if;
  logic                  start;
  logic [7:0]            num_channels;
  logic                  tile_req;
  logic [7:0]            tile_ch;
  logic                  tile_valid;
  logic [5:0][5:0][31:0] tile_a;
  logic [5:0][5:0][31:0] tile_b;
  logic                  mul_start;
  logic [5:0][5:0][31:0] mul_a;
  logic [5:0][5:0][31:0] mul_b;
  logic [5:0][5:0][63:0] mul_c;
  logic                  mul_done;
  logic [5:0][5:0][63:0] acc_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  modport slave (
    input  start, num_channels, tile_valid, tile_a, tile_b, mul_c, mul_done, out_ready,
    output tile_req, tile_ch, mul_start, mul_a, mul_b, acc_out, out_valid, busy
  );

  modport master (
    output start, num_channels, tile_valid, tile_a, tile_b, mul_c, mul_done, out_ready,
    input  tile_req, tile_ch, mul_start, mul_a, mul_b, acc_out, out_valid, busy
  );
endinterface

// File: rtl/winograd_ewmm_accum_ctrl.sv
// Sequences per-channel tile fetch, pointwise multiply and 64-bit accumulation of a
// Winograd-domain 6x6 tile, then presents the summed tile until the consumer takes it.
module winograd_ewmm_accum_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  winograd_ewmm_accum_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_MSTART = 3'd2,
    S_MWAIT  = 3'd3,
    S_ACCUM  = 3'd4,
    S_DRAIN  = 3'd5,
    S_OUTPUT = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            nch_q, nch_d;
  logic [7:0]            ch_q, ch_d;
  logic [7:0]            tile_ch_q, tile_ch_d;
  logic                  tile_req_q, tile_req_d;
  logic                  mul_start_q, mul_start_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [5:0][5:0][31:0] mul_a_q, mul_a_d;
  logic [5:0][5:0][31:0] mul_b_q, mul_b_d;
  logic [5:0][5:0][63:0] acc_q, acc_d;

  // Next-state, datapath update and decode of the registered outputs from the next state
  always_comb begin
    state_d = state_q;
    nch_d   = nch_q;
    ch_d    = ch_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          nch_d = bus.num_channels;
          acc_d = '0;
          ch_d  = 8'd0;
          if (bus.num_channels == 8'd0) begin
            state_d = S_OUTPUT;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.tile_valid) begin
          mul_a_d = bus.tile_a;
          mul_b_d = bus.tile_b;
          state_d = S_MSTART;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MSTART: begin
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (bus.mul_done) begin
          state_d = S_ACCUM;
        end else begin
          state_d = S_MWAIT;
        end
      end
      S_ACCUM: begin
        for (int i = 0; i < 6; i++) begin
          for (int j = 0; j < 6; j++) begin
            acc_d[i][j] = acc_q[i][j] + bus.mul_c[i][j];
          end
        end
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Holding here until mul_done falls keeps the next mul_start off a stale done level.
        if (!bus.mul_done) begin
          if (ch_q == nch_q - 8'd1) begin
            state_d = S_OUTPUT;
          end else begin
            ch_d    = ch_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tile_req_d  = (state_d == S_FETCH);
    mul_start_d = (state_d == S_MSTART);
    out_valid_d = (state_d == S_OUTPUT);
    busy_d      = (state_d != S_IDLE);
    tile_ch_d   = ch_d;
  end

  // State, operand, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nch_q       <= 8'd0;
      ch_q        <= 8'd0;
      tile_ch_q   <= 8'd0;
      tile_req_q  <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      nch_q       <= nch_d;
      ch_q        <= ch_d;
      tile_ch_q   <= tile_ch_d;
      tile_req_q  <= tile_req_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.tile_req  = tile_req_q;
  assign bus.tile_ch   = tile_ch_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.acc_out   = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_winograd_ewmm_accum_ctrl.sv
// Bench for winograd_ewmm_accum_ctrl: directed and random tile runs against a
// sum-of-products reference, with a behavioural multiplier of configurable latency.
module tb_winograd_ewmm_accum_ctrl;

  typedef logic [5:0][5:0][31:0] t32_t;
  typedef logic [5:0][5:0][63:0] t64_t;

  logic clk;
  logic rst_n;
  winograd_ewmm_accum_ctrl_if bus ();

  winograd_ewmm_accum_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   overlap_cnt = 0;
  int   req_rise = 0;
  int   mul_lat = 3;
  int   done_hold = 1;
  bit   req_prev = 1'b0;
  t32_t ta [256];
  t32_t tbm [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input t64_t exp);
    int bi;
    int bj;
    bi = 0;
    bj = 0;
    for (int i = 5; i >= 0; i--) begin
      for (int j = 5; j >= 0; j--) begin
        if (bus.acc_out[i][j] !== exp[i][j]) begin
          bi = i;
          bj = j;
        end
      end
    end
    checks++;
    assert (bus.acc_out === exp) else begin
      failures++;
      $error("FAIL %s acc[%0d][%0d] observed=%h expected=%h", tag, bi, bj,
             bus.acc_out[bi][bj], exp[bi][bj]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tile_req"},  64'(bus.tile_req), 64'd0);
    chk({tag, "_mul_start"}, 64'(bus.mul_start), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_tile_ch"},   64'(bus.tile_ch), 64'd0);
    chk({tag, "_mul_a_zero"}, 64'(bus.mul_a === '0), 64'd1);
    chk({tag, "_mul_b_zero"}, 64'(bus.mul_b === '0), 64'd1);
    chk({tag, "_acc_zero"},   64'(bus.acc_out === '0), 64'd1);
  endtask

  function automatic t32_t const_tile(input logic [31:0] v);
    t32_t t;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) t[i][j] = v;
    return t;
  endfunction

  function automatic t32_t rand_tile();
    t32_t t;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) t[i][j] = $urandom();
    return t;
  endfunction

  // Reference: M = sum over channels of A_k .* B_k, each element modulo 2^64.
  function automatic t64_t ref_acc(input int nch);
    t64_t r;
    r = '0;
    for (int k = 0; k < nch; k++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          r[i][j] = r[i][j] + 64'(ta[k][i][j]) * 64'(tbm[k][i][j]);
    return r;
  endfunction

  // Behavioural multiplier: products appear mul_lat cycles after mul_start and
  // mul_done stays high for done_hold cycles; products are held afterwards.
  initial begin
    t32_t pa;
    t32_t pb;
    t64_t pc;
    bus.mul_done = 1'b0;
    bus.mul_c    = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        pa = bus.mul_a;
        pb = bus.mul_b;
        repeat (mul_lat) @(negedge clk);
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            pc[i][j] = 64'(pa[i][j]) * 64'(pb[i][j]);
        bus.mul_c    = pc;
        bus.mul_done = 1'b1;
        repeat (done_hold) @(negedge clk);
        bus.mul_done = 1'b0;
      end
    end
  end

  // Event counters for mul_start pulses, starts issued while done is high, and tile requests.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        start_cnt++;
        if (bus.mul_done === 1'b1) overlap_cnt++;
      end
      if (bus.tile_req === 1'b1 && !req_prev) req_rise++;
      req_prev = (bus.tile_req === 1'b1);
    end
  end

  // mode 0: plain run; mode 1: stray starts in FETCH and OUTPUT with slow out_ready;
  // mode 2: reset asserted during MWAIT of channel 1.
  task automatic run_op(input int nch, input int mode, input string tag);
    t64_t exp_acc;
    t64_t held;
    int   cyc;
    exp_acc     = ref_acc(nch);
    start_cnt   = 0;
    overlap_cnt = 0;
    req_rise    = 0;
    bus.num_channels = nch[7:0];
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.num_channels = 8'($urandom());
    chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    if (nch == 0) chk({tag, "_out_valid_first"}, 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < nch; k++) begin
      cyc = 0;
      while (bus.tile_req !== 1'b1 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, "_tile_req"}, 64'(bus.tile_req), 64'd1);
      chk({tag, "_tile_ch"}, 64'(bus.tile_ch), 64'(k));
      if (bus.tile_req !== 1'b1) return;
      if (mode == 1 && k == 0) begin
        bus.start        = 1'b1;
        bus.num_channels = 8'd7;
        @(negedge clk);
        bus.start        = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.tile_a     = ta[k];
      bus.tile_b     = tbm[k];
      bus.tile_valid = 1'b1;
      @(negedge clk);
      bus.tile_valid = 1'b0;
      bus.tile_a     = rand_tile();
      bus.tile_b     = rand_tile();
      chk({tag, "_mul_a_cap"}, 64'(bus.mul_a === ta[k]), 64'd1);
      chk({tag, "_mul_b_cap"}, 64'(bus.mul_b === tbm[k]), 64'd1);
      if (mode == 2 && k == 1) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero({tag, "_in_reset"});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk_zero({tag, "_after_late_done"});
        return;
      end
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk_acc({tag, "_acc"}, exp_acc);
    held = bus.acc_out;
    if (mode == 1) begin
      for (int c = 0; c < 5; c++) begin
        bus.start = (c == 2) ? 1'b1 : 1'b0;
        @(negedge clk);
        chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_hold_busy"},  64'(bus.busy), 64'd1);
        chk({tag, "_hold_acc"},   64'(bus.acc_out === held), 64'd1);
      end
      bus.start = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle_busy"},  64'(bus.busy), 64'd0);
    chk({tag, "_acc_kept"},   64'(bus.acc_out === exp_acc), 64'd1);
    chk({tag, "_mul_starts"}, 64'(start_cnt), 64'(nch));
    chk({tag, "_tile_reqs"},  64'(req_rise), 64'(nch));
    chk({tag, "_overlap"},    64'(overlap_cnt), 64'd0);
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      chk({tag, "_not_queued_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_not_queued_req"},  64'(bus.tile_req), 64'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int nch;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.num_channels = 8'd0;
    bus.tile_valid   = 1'b0;
    bus.tile_a       = '0;
    bus.tile_b       = '0;
    bus.out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    ta[0] = const_tile(32'd2);
    tbm[0] = const_tile(32'd3);
    mul_lat = 3;
    done_hold = 1;
    run_op(1, 0, "one_ch");
    chk("one_ch_elem", bus.acc_out[2][3], 64'd6);

    for (int k = 0; k < 3; k++) begin
      ta[k]  = const_tile(32'(k + 1));
      tbm[k] = const_tile(32'd1);
    end
    mul_lat = 2;
    done_hold = 3;
    run_op(3, 0, "three_ch");
    chk("three_ch_elem", bus.acc_out[0][0], 64'd6);

    bus.tile_valid = 1'b1;
    bus.tile_a     = rand_tile();
    @(negedge clk);
    bus.tile_valid = 1'b0;
    @(negedge clk);
    chk("tv_outside_fetch_mul_a", 64'(bus.mul_a === ta[2]), 64'd1);
    chk("tv_outside_fetch_busy", 64'(bus.busy), 64'd0);

    run_op(0, 0, "zero_ch");

    ta[0] = const_tile(32'hFFFF_FFFF);
    ta[1] = const_tile(32'hFFFF_FFFF);
    tbm[0] = const_tile(32'hFFFF_FFFF);
    tbm[1] = const_tile(32'hFFFF_FFFF);
    mul_lat = 1;
    done_hold = 2;
    run_op(2, 0, "wrap");
    chk("wrap_elem", bus.acc_out[5][5], 64'hFFFF_FFFC_0000_0002);

    for (int k = 0; k < 2; k++) begin
      ta[k]  = rand_tile();
      tbm[k] = rand_tile();
    end
    run_op(2, 1, "stray_start");

    for (int k = 0; k < 3; k++) begin
      ta[k]  = rand_tile();
      tbm[k] = rand_tile();
    end
    mul_lat = 4;
    done_hold = 1;
    run_op(3, 2, "rst_mid");
    ta[0]  = rand_tile();
    tbm[0] = rand_tile();
    mul_lat = 3;
    run_op(1, 0, "post_rst");

    for (int r = 0; r < 4; r++) begin
      nch = $urandom_range(1, 6);
      for (int k = 0; k < nch; k++) begin
        ta[k]  = rand_tile();
        tbm[k] = rand_tile();
      end
      mul_lat   = $urandom_range(1, 4);
      done_hold = $urandom_range(1, 3);
      run_op(nch, 0, "rand");
    end

    for (int k = 0; k < 255; k++) begin
      ta[k]  = rand_tile();
      tbm[k] = rand_tile();
    end
    mul_lat = 1;
    done_hold = 1;
    run_op(255, 0, "max_ch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/winograd_ewmm_accum_ctrl.md
WINOGRAD_EWMM_ACCUM_CTRL -- requirements
Module: winograd_ewmm_accum_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, and SHALL use clk and rst_n as the port names.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a tile accumulation; sampled only in IDLE.
REQ-005 num_channels  input  8  channel count; latched on an accepted start.
REQ-006 tile_req  output  1  requests the transformed tile pair for channel tile_ch.
REQ-007 tile_ch  output  8  index of the requested channel.
REQ-008 tile_valid  input  1  tile_a and tile_b are valid; completes the tile_req handshake.
REQ-009 tile_a, tile_b  input  32 x [6][6]  transformed input tile and kernel tile.
REQ-010 mul_start  output  1  start pulse to the shared 6x6 pointwise multiplier.
REQ-011 mul_a, mul_b  output  32 x [6][6]  registered multiplier operands.
REQ-012 mul_c  input  64 x [6][6]  multiplier products.
REQ-013 mul_done  input  1  level from the multiplier; high while mul_c is valid.
REQ-014 acc_out  output  64 x [6][6]  accumulated tile M = sum over k of (A_k .* B_k).
REQ-015 out_valid  output  1  acc_out is valid; held until out_ready.
REQ-016 out_ready  input  1  consumer accepts acc_out.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, MSTART, MWAIT, ACCUM, DRAIN and OUTPUT.
REQ-019 IDLE + start: latch num_channels, clear all 36 accumulators, set ch=0, then go to FETCH, or to OUTPUT if num_channels==0.
REQ-020 FETCH: tile_req=1 and tile_ch=ch are held until tile_valid; on tile_valid, capture tile_a/tile_b into mul_a/mul_b and go to MSTART.
REQ-021 tile_valid outside FETCH SHALL be ignored.
REQ-022 MSTART: mul_start=1 for exactly one cycle, then go to MWAIT.
REQ-023 MWAIT: wait for mul_done==1, then go to ACCUM; there is no timeout.
REQ-024 ACCUM (one cycle): acc[i][j] <= acc[i][j] + mul_c[i][j] for all 36 elements, modulo 2^64 with no saturation, then go to DRAIN.
REQ-025 DRAIN: wait for mul_done==0; if ch==num_channels-1 go to OUTPUT, else ch<=ch+1 and go to FETCH.
REQ-026 Consequence of REQ-025: a new mul_start is never issued while mul_done is high.
REQ-027 OUTPUT: out_valid=1 and acc_out is stable; on out_ready, go to IDLE with out_valid=0 on the next cycle.
REQ-028 acc_out SHALL be driven directly from the accumulator registers and SHALL hold its value after OUTPUT until the next accepted start clears it.
REQ-029 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-030 mul_a and mul_b SHALL hold the last captured operands outside FETCH.
REQ-031 Minimum latency per channel SHALL be 1 (FETCH) + 1 (MSTART) + multiplier latency + 1 (ACCUM) + 1 (DRAIN) cycles, plus tile_valid wait and mul_done fall time.
REQ-032 num_channels==255 SHALL process channels 0..254 with no counter wrap.

Reset
REQ-033 On rst_n low, at any time including mid-operation, the state SHALL be IDLE and tile_req, mul_start, out_valid and busy SHALL be 0.
REQ-034 On rst_n low, tile_ch, ch and all mul_a, mul_b and acc_out elements SHALL be 0.
REQ-035 An in-flight multiplier result arriving after reset SHALL be ignored.
REQ-036 The first start after reset release SHALL behave as a fresh operation.

Verification
REQ-037 num_channels=1, tile_a all 2, tile_b all 3, multiplier model of 3 cycles -> one tile_req with tile_ch=0, one mul_start, acc_out all 6, out_valid until out_ready.
REQ-038 num_channels=3, channel k gives tile_a=k+1 and tile_b=1 -> tile_ch sequence 0,1,2, three mul_start pulses each after mul_done fell, acc_out all 6.
REQ-039 num_channels=0 -> no tile_req and no mul_start; out_valid=1 on the second cycle after start with acc_out all 0.
REQ-040 num_channels=2, a=b=0xFFFFFFFF -> acc_out all 0xFFFFFFFC00000002 (mod 2^64 wrap).
REQ-041 out_ready held low 5 cycles in OUTPUT, with start pulsed during FETCH and OUTPUT -> out_valid and acc_out stable, extra starts ignored, busy=1 throughout.
REQ-042 rst_n pulsed low during MWAIT of channel 1 of 3 -> all outputs 0 immediately; late mul_done ignored; a subsequent num_channels=1 run gives the correct acc_out.
